muldiv_hilo: RTL and testbench
==============================

Name: muldiv_hilo

Overview:
- Multi-cycle multiply/divide unit that owns the architectural HI/LO registers.
- Sits beside the execute-stage ALU. It accepts MULT/MULTU/DIV/DIVU from the decode/issue logic and holds the pipeline via `busy`.
- It supplies HI/LO for MFHI/MFLO forwarding into the ALU result mux, replacing the ALU's combinational divide.
- Iterative: one shift-add or one restoring-divide step per clock.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- ITER, WIDTH, number of iteration cycles per operation.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new operation; sampled only in IDLE.
- op  in  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU.
- s1val  in  WIDTH  rs operand (multiplicand / dividend).
- s2val  in  WIDTH  rt operand (multiplier / divisor).
- mthi  in  1  write s1val into HI (MTHI).
- mtlo  in  1  write s1val into LO (MTLO).
- busy  out  1  operation in progress; the pipeline stalls any HI/LO consumer.
- done  out  1  one-cycle pulse when HI/LO hold a new result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset: synchronous; state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0. Reset asserted mid-operation aborts the operation; no result is written.
- FSM states:
  - IDLE: start=1 latches operands and op at edge E0, goes to RUN. busy=1 from the cycle after E0.
  - RUN: ITER cycles (counter 0..ITER-1), one step per edge E1..E32.
  - FIX: one cycle at E33. Applies sign correction, writes hi/lo, returns to IDLE.
- done/busy timing: done=1 and busy=0 in the cycle following E33, for exactly one cycle. Total latency is 34 cycles from the start edge to the results being visible.
- Signed ops (MULT/DIV):
  - Operate on magnitudes using an unsigned core.
  - Product negated as a 2*WIDTH value when the operand signs differ.
  - Quotient negated when the signs differ; remainder takes the dividend's sign.
- Multiply: {hi,lo} = full 2*WIDTH product.
- Divide: lo = quotient, hi = remainder.
- Divide by zero (either signed or unsigned): lo = all ones, hi = s1val as latched. Sign fix is bypassed.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0 (the natural result of the magnitude path).
- start while busy: ignored. It is not queued and the operands are not relatched.
- start in the done cycle: accepted, since the state is IDLE. The new op begins and the previous result remains in hi/lo until its FIX.
- mthi/mtlo:
  - Written at the next edge only when in IDLE and start=0.
  - When start=1 in the same cycle, start wins and the write is dropped.
  - While busy, the write is dropped.
- hi/lo outputs are registers. They change only on reset, mthi/mtlo, or FIX.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - FSM state encodings (S_IDLE, S_RUN, S_FIX);
  - ITER.
- No sub-module: the FSM, the 2*WIDTH accumulator/remainder register and the sign-fix logic live in one file.
- An optional helper, muldiv_negate (WIDTH-generic two's-complement negate), may be split out if reused.

Test Plan:
- MULTU 0xFFFFFFFF * 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. done exactly 34 cycles after the start edge; busy high for 33 cycles.
- MULT 0xFFFFFFFD (-3) * 5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIVU 100 / 7 → lo=14, hi=2.
- DIV 0xFFFFFFF9 (-7) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 5 / 0 → lo=0xFFFFFFFF, hi=5. DIV 0xFFFFFFFB / 0 → lo=0xFFFFFFFF, hi=0xFFFFFFFB.
- start DIVU 9/2 followed by a second start and mthi (s1val=0x1234) at cycle 5 → both ignored; the result is lo=4, hi=1. rst asserted at cycle 10 of a later op → next cycle busy=0, hi=lo=0, and no done pulse.
- start asserted in the done cycle of a MULTU 2*3 with a new MULTU 4*5 → first result lo=6 visible; second result lo=20 with its done 34 cycles later. mtlo 0xABCD while idle → lo=0xABCD next cycle, hi unchanged.

Source files
------------

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings for the HI/LO multiply/divide unit
package muldiv_pkg;

  localparam int ITER = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_hilo.sv
// rtl/muldiv_hilo.sv - iterative multiply/divide unit owning the HI/LO registers
module muldiv_hilo #(
  parameter int WIDTH = 32,
  parameter int ITER  = muldiv_pkg::ITER
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] s1val,
  input  logic [WIDTH-1:0] s2val,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  import muldiv_pkg::*;

  localparam int CW = $clog2(ITER + 1);

  state_e             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   s1_q;
  logic               is_div, neg_res, neg_rem, div_zero;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               is_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_up, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;

  // Signed ops run on magnitudes; the sign is restored in FIX.
  assign is_signed = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg     = is_signed & s1val[WIDTH-1];
  assign b_neg     = is_signed & s2val[WIDTH-1];
  assign a_mag     = a_neg ? -s1val : s1val;
  assign b_mag     = b_neg ? -s2val : s2val;

  // Shift-add multiply: multiplier sits in the low half and shifts out.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
  assign mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

  // Restoring divide: remainder in the high half, quotient shifts into the low half.
  assign div_up   = acc[2*WIDTH-1:WIDTH-1];
  assign div_diff = div_up - {1'b0, opnd};
  assign div_next = div_diff[WIDTH] ? {div_up[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  assign prod_fix = neg_res ? -acc : acc;
  assign q_fix    = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign r_fix    = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN:  if (cnt == CW'(ITER - 1)) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    done = done_q;
    hi   = hi_q;
    lo   = lo_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      s1_q     <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= (state == S_FIX);
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (start) begin
            is_div   <= (op == OP_DIV) || (op == OP_DIVU);
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            div_zero <= (s2val == '0);
            s1_q     <= s1val;
            if ((op == OP_DIV) || (op == OP_DIVU)) begin
              acc  <= {{WIDTH{1'b0}}, a_mag};
              opnd <= b_mag;
            end else begin
              acc  <= {{WIDTH{1'b0}}, b_mag};
              opnd <= a_mag;
            end
          end else begin
            if (mthi) hi_q <= s1val;
            if (mtlo) lo_q <= s1val;
          end
        end
        S_RUN: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt + CW'(1);
        end
        S_FIX: begin
          if (!is_div) begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end else if (div_zero) begin
            hi_q <= s1_q;
            lo_q <= '1;
          end else begin
            hi_q <= r_fix;
            lo_q <= q_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_hilo.sv
// tb/tb_muldiv_hilo.sv - directed vector bench for muldiv_hilo
module tb_muldiv_hilo;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] s1val, s2val;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  muldiv_hilo dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .s1val(s1val), .s2val(s2val), .mthi(mthi), .mtlo(mtlo),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drives a start for one cycle; returns at the negedge after the start edge.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; s1val = a; s2val = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Steps one edge at a time until done, bounded.
  task automatic wait_done(output int edges, output int busy_cnt);
    edges = 0;
    busy_cnt = 0;
    while (!done && edges < 100) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      edges++;
    end
  endtask

  initial begin
    int edges, bc, dones;

    vecs[0] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2] = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    vecs[3] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5] = '{OP_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
    vecs[6] = '{OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[7] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[8] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[9] = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};

    rst = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; op = 2'b00;
    s1val = '0; s2val = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);

    for (int i = 0; i < NV; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(edges, bc);
      check($sformatf("v%0d_latency", i), edges, 32'd33);
      check($sformatf("v%0d_busy_cycles", i), bc, 32'd33);
      check($sformatf("v%0d_busy_at_done", i), {31'b0, busy}, 32'd0);
      check($sformatf("v%0d_hi", i), hi, vecs[i].ehi);
      check($sformatf("v%0d_lo", i), lo, vecs[i].elo);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), {31'b0, done}, 32'd0);
    end

    // Second start and mthi while busy are both ignored.
    launch(OP_DIVU, 32'd9, 32'd2);
    repeat (4) @(negedge clk);
    start = 1'b1; mthi = 1'b1; op = OP_MULTU; s1val = 32'h1234; s2val = 32'd3;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    wait_done(edges, bc);
    check("busy_ignore_latency", edges, 32'd28);
    check("busy_ignore_lo", lo, 32'd4);
    check("busy_ignore_hi", hi, 32'd1);
    @(negedge clk);

    // Reset mid-operation aborts with no result and no done.
    launch(OP_DIVU, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) dones++;
      @(negedge clk);
    end
    check("abort_no_done", dones, 32'd0);

    // Start accepted in the done cycle.
    launch(OP_MULTU, 32'd2, 32'd3);
    wait_done(edges, bc);
    check("b2b_first_lo", lo, 32'd6);
    start = 1'b1; op = OP_MULTU; s1val = 32'd4; s2val = 32'd5;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", {31'b0, busy}, 32'd1);
    check("b2b_lo_held", lo, 32'd6);
    wait_done(edges, bc);
    check("b2b_second_latency", edges + 1, 32'd34);
    check("b2b_second_lo", lo, 32'd20);
    check("b2b_second_hi", hi, 32'd0);
    @(negedge clk);

    // MTHI/MTLO while idle.
    mthi = 1'b1; s1val = 32'h5555;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi_hi", hi, 32'h5555);
    mtlo = 1'b1; s1val = 32'hABCD;
    @(negedge clk);
    mtlo = 1'b0;
    check("mtlo_lo", lo, 32'hABCD);
    check("mtlo_hi_kept", hi, 32'h5555);

    // start wins over mtlo in the same cycle.
    mtlo = 1'b1;
    launch(OP_MULTU, 32'd7, 32'd1);
    mtlo = 1'b0;
    check("start_wins_lo", lo, 32'hABCD);
    wait_done(edges, bc);
    check("start_wins_result_lo", lo, 32'd7);
    check("start_wins_result_hi", hi, 32'd0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
